// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with a pipeline-wide valid/ready stall.
// Each stage resolves BPS blocks and registers its partial sum, its carry out and the operands.
module csel_adder_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLK   = 4,
   parameter int unsigned BPS   = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int unsigned NBLK = WIDTH / BLK;
   localparam int unsigned NSTG = (NBLK + BPS - 1) / BPS;

   logic             adv;
   logic             vld   [NSTG];
   logic [WIDTH-1:0] sum_q [NSTG];
   logic [WIDTH-1:0] opa_q [NSTG];
   logic [WIDTH-1:0] opb_q [NSTG];
   logic             cry_q [NSTG];
   logic             ovf_q;

   logic [WIDTH-1:0] in_a   [NSTG];
   logic [WIDTH-1:0] in_b   [NSTG];
   logic [WIDTH-1:0] in_s   [NSTG];
   logic             in_c   [NSTG];
   logic [WIDTH-1:0] sum_d  [NSTG];
   logic             cry_d  [NSTG];
   logic             msb_c;

   assign adv      = !vld[NSTG-1] || out_ready;
   assign in_ready = adv;

   always_comb begin
      logic [WIDTH-1:0] nsum;
      logic [BLK-1:0]   s0, s1;
      logic             c, c0, c1, m0, m1;
      int unsigned      blk, bi;
      nsum  = '0;
      s0    = '0;
      s1    = '0;
      c     = 1'b0;
      c0    = 1'b0;
      c1    = 1'b1;
      m0    = 1'b0;
      m1    = 1'b0;
      blk   = 0;
      bi    = 0;
      msb_c = 1'b0;
      // Stage 0 sees the port operands with b already inverted for subtract.
      in_a[0] = a;
      in_b[0] = sub ? ~b : b;
      in_c[0] = sub | cin;
      in_s[0] = '0;
      for (int unsigned k = 1; k < NSTG; k++) begin
         in_a[k] = opa_q[k-1];
         in_b[k] = opb_q[k-1];
         in_c[k] = cry_q[k-1];
         in_s[k] = sum_q[k-1];
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
         nsum = in_s[k];
         c    = in_c[k];
         for (int unsigned j = 0; j < BPS; j++) begin
            blk = k * BPS + j;
            if (blk < NBLK) begin
               c0 = 1'b0;
               c1 = 1'b1;
               for (int unsigned i = 0; i < BLK; i++) begin
                  bi    = blk * BLK + i;
                  s0[i] = in_a[k][bi] ^ in_b[k][bi] ^ c0;
                  s1[i] = in_a[k][bi] ^ in_b[k][bi] ^ c1;
                  if (bi == WIDTH - 1) begin
                     m0 = c0;
                     m1 = c1;
                  end
                  c0 = (in_a[k][bi] & in_b[k][bi]) | (c0 & (in_a[k][bi] ^ in_b[k][bi]));
                  c1 = (in_a[k][bi] & in_b[k][bi]) | (c1 & (in_a[k][bi] ^ in_b[k][bi]));
               end
               nsum[blk*BLK +: BLK] = c ? s1 : s0;
               if (blk == NBLK - 1) msb_c = c ? m1 : m0;
               c = c ? c1 : c0;
            end
         end
         sum_d[k] = nsum;
         cry_d[k] = c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NSTG; k++) begin
            vld[k]   <= 1'b0;
            sum_q[k] <= '0;
            opa_q[k] <= '0;
            opb_q[k] <= '0;
            cry_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         vld[0] <= in_valid;
         for (int unsigned k = 1; k < NSTG; k++) vld[k] <= vld[k-1];
         for (int unsigned k = 0; k < NSTG; k++) begin
            sum_q[k] <= sum_d[k];
            opa_q[k] <= in_a[k];
            opb_q[k] <= in_b[k];
            cry_q[k] <= cry_d[k];
         end
         ovf_q <= msb_c ^ cry_d[NSTG-1];
      end
   end

   assign out_valid = vld[NSTG-1];
   assign sum       = sum_q[NSTG-1];
   assign cout      = cry_q[NSTG-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed-vector and scoreboard bench for csel_adder_pipe at three parameter sets.
module tb_csel_adder_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        iv [3], cin_x [3], sub_x [3], ordy [3];
   logic        ir [3], ov [3], co [3], of [3];
   logic [31:0] a_x [3], b_x [3];
   logic [31:0] s0;
   logic [15:0] s1;
   logic [23:0] s2;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      exp_t        e;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];
   logic held_v;
   exp_t held;

   csel_adder_pipe u_d0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(a_x[0]), .b(b_x[0]), .cin(cin_x[0]), .sub(sub_x[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .ovf(of[0]));

   csel_adder_pipe #(.WIDTH(16), .BLK(4), .BPS(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(a_x[1][15:0]), .b(b_x[1][15:0]), .cin(cin_x[1]), .sub(sub_x[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .ovf(of[1]));

   csel_adder_pipe #(.WIDTH(24), .BLK(4), .BPS(4)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(a_x[2][23:0]), .b(b_x[2][23:0]), .cin(cin_x[2]), .sub(sub_x[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .ovf(of[2]));

   function automatic int unsigned wd(input int d);
      return (d == 0) ? 32 : (d == 1) ? 16 : 24;
   endfunction

   function automatic int nstg(input int d);
      return (d == 2) ? 2 : 4;
   endfunction

   function automatic logic [31:0] get_sum(input int d);
      return (d == 0) ? s0 : (d == 1) ? {16'h0, s1} : {8'h0, s2};
   endfunction

   function automatic exp_t model(input int d, input logic [31:0] av, input logic [31:0] bv,
                                  input logic c, input logic s);
      int unsigned w;
      logic [63:0] m, x, y, t;
      exp_t e;
      w = wd(d);
      m = (64'd1 << w) - 64'd1;
      x = {32'h0, av} & m;
      y = (s ? ~{32'h0, bv} : {32'h0, bv}) & m;
      t = x + y + {63'd0, (s | c)};
      e.sum  = t[31:0] & m[31:0];
      e.cout = t[w];
      e.ovf  = (x[w-1] == y[w-1]) && (t[w-1] != x[w-1]);
      return e;
   endfunction

   function automatic vec_t mk(input logic [31:0] av, input logic [31:0] bv, input logic c,
                               input logic s, input logic [31:0] es, input logic ec,
                               input logic eo);
      vec_t v;
      v.a = av; v.b = bv; v.cin = c; v.sub = s;
      v.e.sum = es; v.e.cout = ec; v.e.ovf = eo;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, want);
      end
   endtask

   // One cycle: drive at the falling edge, sample 1ns later, account for the coming rising edge.
   task automatic step(input int d, input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic c, input logic s, input logic r, input exp_t e,
                       output logic acc);
      exp_t got, want;
      @(negedge clk);
      iv[d] = v; a_x[d] = av; b_x[d] = bv; cin_x[d] = c; sub_x[d] = s; ordy[d] = r;
      #1;
      got.sum = get_sum(d); got.cout = co[d]; got.ovf = of[d];
      if (held_v) begin
         chk("stall_valid", 64'(ov[d]), 64'd1);
         chk("stall_data", 64'(got), 64'(held));
      end
      if (ov[d] && r) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL spurious_out: got %h expected no result", got.sum);
         end else begin
            want = sb.pop_front();
            chk("result", 64'(got), 64'(want));
         end
      end
      held_v = ov[d] && !r;
      held   = got;
      acc    = v && ir[d];
      if (acc) sb.push_back(e);
   endtask

   task automatic directed(input int d, input vec_t t, input string name);
      logic acc;
      int   lat;
      held_v = 1'b0;
      step(d, 1'b1, t.a, t.b, t.cin, t.sub, 1'b1, t.e, acc);
      chk({name, "_accept"}, 64'(acc), 64'd1);
      lat = 0;
      while (lat < 20) begin
         step(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, t.e, acc);
         lat++;
         if (ov[d]) break;
      end
      chk({name, "_latency"}, 64'(lat), 64'(nstg(d)));
      chk({name, "_drained"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   task automatic rand_test(input int d, input int n, input string name);
      logic        acc, r;
      logic [31:0] ra, rb, m;
      logic        rc, rs;
      int          i, cyc;
      held_v = 1'b0;
      m  = (wd(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wd(d)) - 32'd1);
      ra = $urandom & m; rb = $urandom & m;
      rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      i = 0; cyc = 0;
      while ((i < n || sb.size() != 0) && cyc < 2000) begin
         r = ($urandom_range(0, 2) != 0);
         step(d, (i < n), ra, rb, rc, rs, r, model(d, ra, rb, rc, rs), acc);
         if (acc) begin
            i++;
            ra = $urandom & m; rb = $urandom & m;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
         end
         cyc++;
      end
      checks++;
      if (i < n || sb.size() != 0) begin
         errors++;
         $display("FAIL %s_complete: got %0d sent %0d pending, required %0d sent 0 pending",
                  name, i, sb.size(), n);
      end
      sb.delete();
      held_v = 1'b0;
      for (int k = 0; k < 6; k++) step(d, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, '0, acc);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tab [8];
      logic acc;
      tab[0] = mk(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      tab[1] = mk(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0, 1'b0);
      tab[2] = mk(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      tab[3] = mk(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      tab[4] = mk(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      tab[5] = mk(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
      tab[6] = mk(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tab[7] = mk(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1);

      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; cin_x[d] = 1'b0; sub_x[d] = 1'b0; ordy[d] = 1'b1;
         a_x[d] = '0; b_x[d] = '0;
      end
      held_v = 1'b0;
      held   = '0;

      // reset held for three cycles with operands offered
      rst = 1'b1;
      iv[0] = 1'b1; a_x[0] = 32'hFFFF_FFFF; b_x[0] = 32'h1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_out_valid", 64'(ov[0]), 64'd0);
      chk("rst_sum", 64'(s0), 64'd0);
      chk("rst_cout", 64'(co[0]), 64'd0);
      chk("rst_ovf", 64'(of[0]), 64'd0);
      chk("rst_out_valid_d1", 64'(ov[1]), 64'd0);
      chk("rst_out_valid_d2", 64'(ov[2]), 64'd0);
      rst = 1'b0; iv[0] = 1'b0; ordy[0] = 1'b0;
      #1;
      chk("rst_in_ready", 64'(ir[0]), 64'd1);
      for (int k = 0; k < 6; k++) begin
         step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, '0, acc);
         chk("post_rst_idle", 64'(ov[0]), 64'd0);
      end

      foreach (tab[i]) directed(0, tab[i], $sformatf("vec%0d", i));

      rand_test(0, 16, "rand_w32");

      // reset while three transactions are in flight
      held_v = 1'b0;
      for (int k = 0; k < 3; k++)
         step(0, 1'b1, 32'(k + 10), 32'h5, 1'b0, 1'b0, 1'b1, model(0, 32'(k + 10), 32'h5, 1'b0, 1'b0), acc);
      @(negedge clk);
      iv[0] = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(ov[0]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      for (int k = 0; k < 6; k++) begin
         step(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, '0, acc);
         chk("midrst_flushed", 64'(ov[0]), 64'd0);
      end
      directed(0, mk(32'h1, 32'h2, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0), "post_rst");

      directed(1, mk(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0), "w16_carry");
      directed(1, mk(32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1), "w16_sub");
      rand_test(1, 16, "rand_w16");

      directed(2, mk(32'h007F_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0080_0000, 1'b0, 1'b1), "w24_ovf");
      directed(2, mk(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h00FF_FFFE, 1'b0, 1'b0), "w24_sub");
      rand_test(2, 16, "rand_w24");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/csel_adder_pipe.md
# csel_adder_pipe

Parametrised, pipelined carry-select adder/subtractor with valid/ready handshakes. It generalises the team's fixed 32-bit, 4-bit-block combinational carry-select adder. Width, block size and blocks-per-stage are set by parameters. It adds a subtract mode and a signed-overflow flag, and registers the carry chain across pipeline stages so it can sit directly in the datapath between registered producer/consumer interfaces.

## Interface
- WIDTH, 32: operand width; must be a multiple of BLK.
- BLK, 4: bits per carry-select block.
- BPS, 2: blocks evaluated per pipeline stage. NBLK = WIDTH/BLK; NSTG = ceil(NBLK/BPS), which is 4 at the defaults.
- clk  in  1  clock; all flops rise-edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; in sub mode, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Acceptance: a transaction is accepted on a rising edge with in_valid && in_ready.
  - At acceptance, b is replaced by ~b when sub=1.
  - The effective carry-in is (sub ? 1 : cin).
- Stage k (0..NSTG-1) resolves blocks k*BPS to min(k*BPS+BPS, NBLK)-1.
  - Each block computes two ripple sums, one with carry-in 0 and one with carry-in 1.
  - The actual incoming carry selects between them, mux-chained through the stage.
  - Block 0 may ripple directly with the real carry-in.
- Per-stage registers:
  - valid bit;
  - resolved sum bits so far;
  - carry out of the stage's last block;
  - unprocessed upper operand bits.
- The last stage also produces the carry into the MSB, from bit WIDTH-2 of the final block, for ovf.
- Output registers are the last-stage registers: sum, cout, ovf, out_valid.
- Stall is pipeline-wide. adv = !out_valid || out_ready, and in_ready = adv.
  - When adv=0, every stage register holds.
  - Bubbles (invalid stages) are not collapsed.
- Empty stages still advance, so an invalid entry shifts through. Data registers may load don't-care values when their valid bit is 0.
- Results leave in acceptance order. No transaction is dropped or duplicated.

## Timing
- Reset (asynchronous, while rst=1):
  - all valid bits clear, so out_valid=0;
  - sum=0, cout=0, ovf=0;
  - in_ready=1 once out_valid=0.
- Reset mid-operation discards every in-flight transaction. The first accept after rst falls is processed normally.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+NSTG−1 when no stall occurs, i.e. NSTG register stages. At the defaults this is 4 stages: accept at edge 0, result registered at edge 3.
- Throughput is one transaction per cycle while out_ready=1.
- While out_valid=1 and out_ready=0:
  - sum/cout/ovf/out_valid are stable;
  - in_ready=0 in the same cycle (combinational from out_valid/out_ready).
- A simultaneous output pop and input accept in one cycle is legal. No extra bubble is inserted.
- in_ready depends only on registered out_valid and the out_ready input. There is no combinational path from in_valid, a or b to in_ready.
- Widths:
  - internal carries are 1 bit per block;
  - sum is exactly WIDTH bits;
  - a partial last stage (NBLK not divisible by BPS) is allowed and still costs one full stage.

## Test plan
- Reset: hold rst=1 for 3 cycles with in_valid=1 → out_valid=0, sum=0, cout=0, ovf=0. After release, in_ready=1 and no spurious output.
- Full carry propagation: a=FFFFFFFF, b=00000001, cin=0, sub=0 → after 4 stages: sum=00000000, cout=1, ovf=0. Then a=0, b=0, cin=1 → sum=00000001, cout=0.
- Signed overflow add: a=7FFFFFFF, b=00000001, cin=0 → sum=80000000, cout=0, ovf=1.
- Subtract:
  - a=5, b=7, sub=1, cin=1 (ignored) → sum=FFFFFFFE, cout=0, ovf=0.
  - a=80000000, b=1, sub=1 → sum=7FFFFFFF, cout=1, ovf=1.
- Back-pressure: 16 random back-to-back transactions with out_ready toggling pseudo-randomly → results match a reference model, are in order, with no loss or duplication; outputs stay stable while stalled.
- Reset mid-flight: accept 3 transactions, assert rst for 1 cycle before any output → no result ever appears for them. A post-reset transaction a=1, b=2 → sum=3 after 4 stages.
- Parameter sweep: repeat the add/sub random checks with (WIDTH=16, BLK=4, BPS=1) and (WIDTH=24, BLK=4, BPS=4; partial last stage) → NSTG = 4 and 2 respectively; results correct.
